// File: rtl/eth10_pkg.sv
// Shared state encoding, framing constants and counter helper for the 10BASE-T transmit serializer.
package eth10_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
      PAD,
      FCS,
      IFG
   } state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          PRE_BYTES     = 7;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam int          FCS_BITS      = 32;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

endpackage

// File: rtl/eth10_crc32_serial.sv
// Bit-serial reflected CRC-32; result visible one clock after each enabled bit.
// No backpressure: en qualifies each bit, init reloads the seed.
module eth10_crc32_serial
   import eth10_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        bit_in,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || init) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= (crc >> 1) ^ ((crc[0] ^ bit_in) ? CRC_POLY : 32'h0);
      end
   end

endmodule

// File: rtl/eth10_tx_frame_ser.sv
// Byte stream to framed serial NRZ: first preamble bit one clock after in_valid seen in IDLE.
// in_ready pulses only at byte load points; a missing byte there aborts the frame (underrun).
module eth10_tx_frame_ser
   import eth10_pkg::*;
#(
   parameter int CLK_PER_BIT = 1,
   parameter int MIN_PAYLOAD = 60,
   parameter int IFG_BITS    = 96
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       TxData,
   output logic       tx_en,
   output logic       busy,
   output logic       underrun
);

   localparam logic [15:0] TICK_LAST = 16'(CLK_PER_BIT - 1);
   localparam logic [15:0] PRE_LAST  = 16'(PRE_BYTES * 8 - 1);
   localparam logic [15:0] FCS_LAST  = 16'(FCS_BITS - 1);
   localparam logic [15:0] IFG_LAST  = 16'(IFG_BITS - 1);
   localparam logic [10:0] MIN_CNT   = 11'(MIN_PAYLOAD);

   state_t      state, state_n;
   logic [15:0] tick_cnt, tick_cnt_n;
   logic [15:0] bit_cnt, bit_cnt_n;
   logic [7:0]  sh, sh_n;
   logic [10:0] byte_cnt, byte_cnt_n;
   logic        last_seen, last_seen_n;
   logic        underrun_n;
   logic        tick, load_pt, byte_end;
   logic        crc_en, crc_bit;
   logic [31:0] crc;

   assign tick     = (tick_cnt == TICK_LAST);
   assign byte_end = tick && (bit_cnt == 16'd7);
   assign load_pt  = byte_end && ((state == SFD) || (state == DATA && !last_seen));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         sh        <= '0;
         byte_cnt  <= '0;
         last_seen <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         bit_cnt   <= bit_cnt_n;
         sh        <= sh_n;
         byte_cnt  <= byte_cnt_n;
         last_seen <= last_seen_n;
         underrun  <= underrun_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      sh_n        = sh;
      byte_cnt_n  = byte_cnt;
      last_seen_n = last_seen;
      underrun_n  = 1'b0;
      in_ready    = load_pt;
      tick_cnt_n  = (state == IDLE || tick) ? 16'd0 : tick_cnt + 16'd1;

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n     = PRE;
               bit_cnt_n   = '0;
               sh_n        = PREAMBLE_BYTE;
               byte_cnt_n  = '0;
               last_seen_n = 1'b0;
            end
         end
         PRE: begin
            if (tick) begin
               if (bit_cnt == PRE_LAST) begin
                  state_n   = SFD;
                  bit_cnt_n = '0;
                  sh_n      = SFD_BYTE;
               end else begin
                  bit_cnt_n = bit_cnt + 16'd1;
                  sh_n      = (bit_cnt[2:0] == 3'd7) ? PREAMBLE_BYTE : sh >> 1;
               end
            end
         end
         SFD, DATA: begin
            if (tick && !byte_end) begin
               bit_cnt_n = bit_cnt + 16'd1;
               sh_n      = sh >> 1;
            end else if (load_pt) begin
               bit_cnt_n = '0;
               if (in_valid) begin
                  state_n     = DATA;
                  sh_n        = in_data;
                  byte_cnt_n  = sat_inc(byte_cnt);
                  last_seen_n = in_last;
               end else begin
                  state_n    = IFG;
                  underrun_n = 1'b1;
               end
            end else if (byte_end) begin
               // Final byte done: byte_cnt already counts it, so it decides pad vs FCS.
               bit_cnt_n = '0;
               if (byte_cnt < MIN_CNT) begin
                  state_n    = PAD;
                  sh_n       = '0;
                  byte_cnt_n = sat_inc(byte_cnt);
               end else begin
                  state_n = FCS;
               end
            end
         end
         PAD: begin
            if (tick && !byte_end) begin
               bit_cnt_n = bit_cnt + 16'd1;
            end else if (byte_end) begin
               bit_cnt_n = '0;
               if (byte_cnt >= MIN_CNT) begin
                  state_n = FCS;
               end else begin
                  byte_cnt_n = sat_inc(byte_cnt);
               end
            end
         end
         FCS: begin
            if (tick) begin
               if (bit_cnt == FCS_LAST) begin
                  state_n   = IFG;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + 16'd1;
               end
            end
         end
         IFG: begin
            if (tick) begin
               if (bit_cnt == IFG_LAST) begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + 16'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // During FCS the register is fed its own LSB, which zeroes the feedback and turns it into a plain shifter.
   assign crc_en  = tick && (state == DATA || state == PAD || state == FCS);
   assign crc_bit = (state == FCS) ? crc[0] : sh[0];

   eth10_crc32_serial u_crc (
      .clk    (clk),
      .rst    (rst),
      .init   (state == SFD),
      .en     (crc_en),
      .bit_in (crc_bit),
      .crc    (crc)
   );

   assign tx_en  = (state == PRE) || (state == SFD) || (state == DATA) ||
                   (state == PAD) || (state == FCS);
   assign busy   = (state != IDLE);
   assign TxData = tx_en & ((state == FCS) ? ~crc[0] : sh[0]);

endmodule
